drum_timing_gen: RTL

//   Consumes the one-clock tick pulses from the timer and turns them into G-15 drum timing.

---
 rtl/drum_timing_gen_if.sv | 29 ++
 rtl/drum_timing_gen.sv | 128 ++++++++++++
 2 files changed

// File: rtl/drum_timing_gen_if.sv
// Handshake/bus bundle between the timer-side driver and the drum timing generator.
// The master drives tick/enable/sync_req; the slave (the generator) drives drum position and status.
interface drum_timing_gen_if;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned WORD_W = 7;

  logic              tick;
  logic              enable;
  logic              sync_req;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word_cnt;
  logic              t0;
  logic              t28;
  logic              odd_word;
  logic              word_end;
  logic              rev_end;
  logic              running;
  logic              tick_fault;

  modport master (
    output tick, enable, sync_req,
    input  bit_cnt, word_cnt, t0, t28, odd_word, word_end, rev_end, running, tick_fault
  );

  modport slave (
    input  tick, enable, sync_req,
    output bit_cnt, word_cnt, t0, t28, odd_word, word_end, rev_end, running, tick_fault
  );
endinterface

// File: rtl/drum_timing_gen.sv
// G-15 drum timing: turns timer ticks into bit-time / word-time position,
// with word/revolution pulses and a missing-tick watchdog.
module drum_timing_gen #(
  parameter int unsigned BITS_PER_WORD = 29,
  parameter int unsigned WORDS_PER_REV = 108,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic             clk,
  input  logic             rst,
  drum_timing_gen_if.slave bus
);

  localparam int unsigned BIT_W  = 5;
  localparam int unsigned WORD_W = 7;
  localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              word_end_q, word_end_d;
  logic              rev_end_q, rev_end_d;
  logic              last_bit;
  logic              last_word;
  logic              wdog_expire;

  // State and position registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_q      <= '0;
      word_q     <= '0;
      wdog_q     <= '0;
      word_end_q <= 1'b0;
      rev_end_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      wdog_q     <= wdog_d;
      word_end_q <= word_end_d;
      rev_end_q  <= rev_end_d;
    end
  end

  // Next-state: sync_req overrides everything, then enable, then tick
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    word_d      = word_q;
    wdog_d      = wdog_q;
    word_end_d  = 1'b0;
    rev_end_d   = 1'b0;
    last_bit    = (bit_q == BIT_W'(BITS_PER_WORD - 1));
    last_word   = (word_q == WORD_W'(WORDS_PER_REV - 1));
    wdog_expire = (wdog_q >= WD_W'(TIMEOUT - 1));

    if (bus.sync_req) begin
      bit_d   = '0;
      word_d  = '0;
      wdog_d  = '0;
      state_d = bus.enable ? S_RUN : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          wdog_d = '0;
          if (bus.enable) begin
            state_d = S_RUN;
          end
        end

        S_RUN: begin
          if (!bus.enable) begin
            state_d = S_IDLE;
            wdog_d  = '0;
          end else if (bus.tick) begin
            wdog_d = '0;
            if (last_bit) begin
              bit_d      = '0;
              word_end_d = 1'b1;
              if (last_word) begin
                word_d    = '0;
                rev_end_d = 1'b1;
              end else begin
                word_d = word_q + WORD_W'(1);
              end
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else if (wdog_expire) begin
            // Watchdog saturates at TIMEOUT and parks the generator in FAULT
            wdog_d  = WD_W'(TIMEOUT);
            state_d = S_FAULT;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end

        S_FAULT: begin
          wdog_d = WD_W'(TIMEOUT);
        end

        default: begin
          state_d = S_IDLE;
          wdog_d  = '0;
        end
      endcase
    end
  end

  // t0/t28 decode straight from the position register so they hold in every state
  assign bus.bit_cnt    = bit_q;
  assign bus.word_cnt   = word_q;
  assign bus.t0         = (bit_q == '0);
  assign bus.t28        = last_bit;
  assign bus.odd_word   = word_q[0];
  assign bus.word_end   = word_end_q;
  assign bus.rev_end    = rev_end_q;
  assign bus.running    = (state_q == S_RUN);
  assign bus.tick_fault = (state_q == S_FAULT);

endmodule
